// File: rtl/posit_mul_pkg.sv
// Shared types for the posit mantissa multiplier: Booth digits, FSM states and the radix-4 recoder.
package posit_mul_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // grp = {b[2i+1], b[2i], b[2i-1]}
  function automatic booth_digit_t booth_recode(input logic [2:0] grp);
    booth_digit_t d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/radix4_booth_pp.sv
// Booth partial product: digit * a as a (WIDTH+2)-bit signed value, purely combinational.
module radix4_booth_pp
  import posit_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        a,
  input  booth_digit_t            digit,
  output logic signed [WIDTH+1:0] pp
);

  logic signed [WIDTH+1:0] ax;

  assign ax = signed'({2'b00, a});

  always_comb begin
    pp = '0;
    case (digit)
      POS1:    pp = ax;
      POS2:    pp = ax <<< 1;
      NEG1:    pp = -ax;
      NEG2:    pp = -(ax <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/radix4_booth_seq_mult.sv
// Sequential unsigned radix-4 Booth multiplier, one group per cycle, valid/ready on both sides.
// RADIX4_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module radix4_booth_seq_mult
  import posit_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NGRP = WIDTH / 2 + 1;
  localparam int GW   = $clog2(NGRP + 1);
  localparam int AW   = 2 * WIDTH + 2;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        a_q, b_q;
  logic [GW-1:0]           grp;
  logic signed [AW-1:0]    acc;
  logic [WIDTH+2:0]        b_rec;
  logic [2:0]              grp_bits;
  booth_digit_t            digit;
  logic signed [WIDTH+1:0] pp;
  logic signed [AW-1:0]    pp_sh;
  logic                    last_grp;

  // Two zero bits on top make the unsigned multiplier recode as a positive number.
  assign b_rec = {2'b00, b_q, 1'b0};

  always_comb begin
    grp_bits = 3'(b_rec >> (2 * int'(grp)));
    digit    = booth_recode(grp_bits);
    pp_sh    = AW'(pp) <<< (2 * int'(grp));
    last_grp = (int'(grp) == NGRP - 1);
`ifdef RADIX4_EARLY_TERM_EN
    last_grp = last_grp || ((b_q >> (2 * int'(grp) + 1)) == '0);
`endif
  end

  radix4_booth_pp #(.WIDTH(WIDTH)) u_pp (
    .a     (a_q),
    .digit (digit),
    .pp    (pp)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    product   = out_valid ? acc[2*WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      grp   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          acc <= '0;
          grp <= '0;
        end
        RUN: begin
          acc <= acc + pp_sh;
          grp <= grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Bench for radix4_booth_seq_mult: directed cases at WIDTH=8, then throttled random traffic at WIDTH=8 and 16.
module tb_radix4_booth_seq_mult;

  localparam int NGRP8 = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid8, out_ready8, in_valid16, out_ready16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        in_ready8, out_valid8, in_ready16, out_valid16;
  logic [15:0] product8;
  logic [31:0] product16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  radix4_booth_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(product8)
  );

  radix4_booth_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .product(product16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycles from the accepting edge to the edge that first samples out_valid.
  function automatic int exp_lat(input logic [7:0] bv);
`ifdef RADIX4_EARLY_TERM_EN
    for (int i = 0; i < NGRP8; i++)
      if ((32'(bv) >> (2 * i + 1)) == 32'd0) return i + 2;
    return NGRP8 + 1;
`else
    return NGRP8 + 1;
`endif
  endfunction

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input int stall);
    int          k;
    int          lat;
    logic [15:0] held;
    logic [15:0] exp;
    exp = 16'(ta) * 16'(tbv);
    k = 0;
    while (!in_ready8 && k < 50) begin @(negedge clk); k++; end
    check("in_ready_idle", 64'(in_ready8), 64'd1);
    a8 = ta; b8 = tbv; in_valid8 = 1'b1; out_ready8 = (stall == 0);
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = -1; k = 0;
    while (k < 50) begin
      if (out_valid8) begin lat = k + 1; break; end
      @(negedge clk); k++;
    end
    check("latency", 64'(lat), 64'(exp_lat(tbv)));
    check("product", 64'(product8), 64'(exp));
    if (stall > 0) begin
      held = product8;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", 64'(out_valid8), 64'd1);
        check("stall_prod", 64'(product8), 64'(held));
        check("stall_in_ready", 64'(in_ready8), 64'd0);
      end
      out_ready8 = 1'b1;
      check("in_ready_at_release", 64'(in_ready8), 64'd0);
    end
    @(negedge clk);
    check("out_valid_drop", 64'(out_valid8), 64'd0);
    check("in_ready_back", 64'(in_ready8), 64'd1);
    out_ready8 = 1'b0;
  endtask

  function automatic logic [15:0] pick(input int bits);
    int          m;
    logic [15:0] mask;
    mask = 16'((32'd1 << bits) - 1);
    m = $urandom_range(0, 7);
    if (m == 0) return 16'd0;
    if (m == 1) return mask;
    if (m == 2) return 16'($urandom_range(0, 7));
    return 16'($urandom) & mask;
  endfunction

  task automatic rand_run(input bit wide, input int n);
    int          sent, got, cyc;
    logic [31:0] q[$];
    logic [31:0] cur_p, prev_prod;
    logic [15:0] ra, rb;
    logic        cur_ov, cur_ir, iv, ordy;
    bit          prev_stall, xfer;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; xfer = 0; iv = 0;
    ra = '0; rb = '0; prev_prod = '0;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      cur_ov = wide ? out_valid16 : out_valid8;
      cur_ir = wide ? in_ready16  : in_ready8;
      cur_p  = wide ? product16   : 32'(product8);
      if (prev_stall) begin
        check("hold_valid", 64'(cur_ov), 64'd1);
        check("hold_prod", 64'(cur_p), 64'(prev_prod));
      end
      if (cur_ov)
        check("acc_upper", wide ? 64'(u16.acc[33:32]) : 64'(u8.acc[17:16]), 64'd0);
      ordy = ($urandom_range(0, 2) != 0);
      if (cur_ov && ordy) begin
        if (q.size() == 0) check("extra_output", 64'd1, 64'd0);
        else check("rand_prod", 64'(cur_p), 64'(q.pop_front()));
        got++;
      end
      prev_stall = cur_ov && !ordy;
      prev_prod  = cur_p;
      if (xfer) begin iv = 1'b0; xfer = 0; end
      if (!iv && sent < n && $urandom_range(0, 3) != 0) begin
        iv = 1'b1;
        ra = pick(wide ? 16 : 8);
        rb = pick(wide ? 16 : 8);
      end
      if (iv && cur_ir) begin
        q.push_back(32'(ra) * 32'(rb));
        sent++;
        xfer = 1;
      end
      if (wide) begin
        in_valid16 = iv; a16 = ra; b16 = rb; out_ready16 = ordy;
      end else begin
        in_valid8 = iv; a8 = ra[7:0]; b8 = rb[7:0]; out_ready8 = ordy;
      end
    end
    check(wide ? "count16" : "count8", 64'(got), 64'(n));
    check(wide ? "left16" : "left8", 64'(q.size()), 64'd0);
    in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready8 = 1'b1; out_ready16 = 1'b1;
    repeat (25) @(negedge clk);
    check(wide ? "idle_valid16" : "idle_valid8", wide ? 64'(out_valid16) : 64'(out_valid8), 64'd0);
    out_ready8 = 1'b0; out_ready16 = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready8", 64'(in_ready8), 64'd1);
    check("rst_out_valid8", 64'(out_valid8), 64'd0);
    check("rst_product8", 64'(product8), 64'd0);
    check("rst_in_ready16", 64'(in_ready16), 64'd1);
    check("rst_product16", 64'(product16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'hFF, 8'hFF, 0);
    do_op(8'h80, 8'h03, 0);
    do_op(8'h5A, 8'h00, 0);
    do_op(8'h00, 8'hB7, 0);
    do_op(8'h12, 8'h34, 10);
    do_op(8'hAA, 8'h55, 0);

    // Reset sampled three edges into a multiply.
    a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_in_ready", 64'(in_ready8), 64'd1);
    check("midrun_rst_out_valid", 64'(out_valid8), 64'd0);
    check("midrun_rst_product", 64'(product8), 64'd0);
    do_op(8'h03, 8'h05, 0);

    rand_run(1'b0, 1500);
    rand_run(1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
